// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR pseudo-random generator.
// Mode encodings and known maximal-length tap masks.
package lfsr_pkg;

  localparam int MODE_FIBONACCI = 0;
  localparam int MODE_GALOIS    = 1;

  localparam logic [3:0]  TAPS_W4  = 4'h9;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

endpackage

// File: rtl/lfsr_core.sv
// Combinational LFSR step: next state and output bit.
// Fibonacci shifts left with XOR feedback; Galois shifts right with toggles.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W8,
  parameter int               MODE  = MODE_FIBONACCI
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next,
  output logic             out_bit
);

  // Select the step rule for the configured mode
  always_comb begin
    next    = '0;
    out_bit = 1'b0;
    if (MODE == MODE_GALOIS) begin
      out_bit = state[0];
      next    = (state >> 1) ^ (state[0] ? TAPS : '0);
    end else begin
      out_bit = state[WIDTH-1];
      next    = {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_prng.sv
// Gated LFSR random source with seed load, word collector,
// valid/ready word output and period-wrap flag.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int                  WIDTH    = 8,
  parameter logic [WIDTH-1:0]    TAPS     = TAPS_W8,
  parameter int                  MODE     = MODE_FIBONACCI,
  parameter logic [WIDTH-1:0]    SEED     = 8'h01,
  parameter int                  OUT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                seed_valid,
  input  logic [WIDTH-1:0]    seed_data,
  output logic                seed_ready,
  output logic                out_bit,
  output logic [OUT_BITS-1:0] word_data,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                wrap,
  output logic                seed_zero
);

  localparam int CW = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_BITS - 1);
  localparam logic [WIDTH-1:0] RST_STATE =
    (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0]    state_q, state_d;
  logic [WIDTH-1:0]    anchor_q, anchor_d;
  logic [OUT_BITS-1:0] col_q, col_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OUT_BITS-1:0] word_q, word_d;
  logic                wvalid_q, wvalid_d;
  logic                wrap_q, wrap_d;
  logic                szero_q, szero_d;

  logic [WIDTH-1:0]    core_next;
  logic                core_bit;
  logic [WIDTH-1:0]    seed_fix;
  logic [OUT_BITS-1:0] col_shift;
  logic                load;
  logic                at_last;
  logic                stall;
  logic                step;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MODE)
  ) u_core (
    .state   (state_q),
    .next    (core_next),
    .out_bit (core_bit)
  );

  // Control: seed priority, back-pressure stall, step qualify
  always_comb begin
    seed_ready = ~rst;
    load       = seed_valid & seed_ready;
    at_last    = (cnt_q == LAST);
    stall      = wvalid_q & ~word_ready & at_last;
    step       = en & ~stall & ~load;
    seed_fix   = (seed_data == '0) ? WIDTH'(1) : seed_data;
    col_shift  = {col_q[OUT_BITS-2:0], core_bit};
  end

  // LFSR state and period anchor update
  always_comb begin
    state_d  = state_q;
    anchor_d = anchor_q;
    wrap_d   = 1'b0;
    szero_d  = 1'b0;
    if (load) begin
      state_d  = seed_fix;
      anchor_d = seed_fix;
      szero_d  = (seed_data == '0);
    end else if (step) begin
      state_d  = core_next;
      wrap_d   = (core_next == anchor_q);
    end
  end

  // Bit collector and word handshake; a pending word is never lost
  always_comb begin
    col_d    = col_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    wvalid_d = wvalid_q;
    if (wvalid_q & word_ready) begin
      wvalid_d = 1'b0;
    end
    if (load) begin
      col_d = '0;
      cnt_d = '0;
    end else if (step) begin
      col_d = col_shift;
      if (at_last) begin
        cnt_d    = '0;
        word_d   = col_shift;
        wvalid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // LFSR registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      anchor_q <= RST_STATE;
    end else begin
      state_q  <= state_d;
      anchor_q <= anchor_d;
    end
  end

  // Collector and word registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      wvalid_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      wvalid_q <= wvalid_d;
    end
  end

  // Event pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q  <= 1'b0;
      szero_q <= 1'b0;
    end else begin
      wrap_q  <= wrap_d;
      szero_q <= szero_d;
    end
  end

  assign out_bit    = core_bit;
  assign word_data  = word_q;
  assign word_valid = wvalid_q;
  assign wrap       = wrap_q;
  assign seed_zero  = szero_q;

endmodule
